// File: rtl/icache_model_mem.sv
// icache_model_mem: loadable instruction-memory model answering the core fetch port
// with a configurable fetch latency, error flagging and a saturating read counter.
module icache_model_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 64,
  parameter int LATENCY = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        iCacheReadAddr,
  input  logic                     iCacheReadEn,
  output logic [DATA_W-1:0]        iCacheReadData,
  output logic                     iCacheReadValid,
  input  logic                     loadEn,
  input  logic [$clog2(DEPTH)-1:0] loadIdx,
  input  logic [DATA_W-1:0]        loadData,
  output logic                     fetchErr,
  output logic [15:0]              readCount
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic bad;
  logic [DATA_W-1:0] word;
  assign idx = iCacheReadAddr[AW+1:2];
  assign bad = (iCacheReadAddr[1:0] != 2'b00) || ((iCacheReadAddr >> (AW + 2)) != '0);
  assign word = bad ? NOP_WORD : mem[idx];
  // Array has no reset so a loader may fill it while rst is held.
  always_ff @(posedge clk)
    if (loadEn) mem[loadIdx] <= loadData;
  always_ff @(posedge clk or posedge rst)
    if (rst) fetchErr <= 1'b0;
    else if (iCacheReadEn && bad) fetchErr <= 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) readCount <= '0;
    else if (iCacheReadValid && readCount != 16'hFFFF) readCount <= readCount + 16'd1;
  if (LATENCY == 0) begin : g_comb
    logic [DATA_W-1:0] lastData;
    always_ff @(posedge clk or posedge rst)
      if (rst) lastData <= NOP_WORD;
      else if (iCacheReadEn) lastData <= word;
    assign iCacheReadValid = iCacheReadEn && !rst;
    assign iCacheReadData = rst ? NOP_WORD : (iCacheReadEn ? word : lastData);
  end else begin : g_pipe
    logic vld [LATENCY];
    logic [DATA_W-1:0] dat [LATENCY];
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
      logic inV;
      logic [DATA_W-1:0] inD;
      if (s == 0) begin : g_head
        assign inV = iCacheReadEn;
        assign inD = word;
      end else begin : g_body
        assign inV = vld[s-1];
        assign inD = dat[s-1];
      end
      // Bubbles keep the previous data so the output holds the last completed word.
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          vld[s] <= 1'b0;
          dat[s] <= NOP_WORD;
        end else begin
          vld[s] <= inV;
          if (inV) dat[s] <= inD;
        end
    end
    assign iCacheReadValid = vld[LATENCY-1];
    assign iCacheReadData = dat[LATENCY-1];
  end
endmodule
